// File: rtl/chat_pkg.sv
// rtl/chat_pkg.sv - shared state encoding and ASCII constants for the chat session controller
package chat_pkg;

  localparam logic [2:0] ST_LOGIN     = 3'd0;
  localparam logic [2:0] ST_PASSWORD  = 3'd1;
  localparam logic [2:0] ST_SENDING   = 3'd2;
  localparam logic [2:0] ST_RECEIVING = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ONE = 8'h31;

endpackage

// File: rtl/pw_checker.sv
// rtl/pw_checker.sv - password entry buffer with backspace and match result for the current key
module pw_checker import chat_pkg::*; #(
  parameter int NUM_USERS = 2,
  parameter int PW_LEN    = 1,
  localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int IW = (PW_LEN > 1) ? $clog2(PW_LEN) : 1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          clear,
  input  logic                          key_valid,
  input  logic [7:0]                    key_ascii,
  input  logic [UW-1:0]                 user_id,
  input  logic [NUM_USERS*PW_LEN*8-1:0] pw_table,
  output logic                          last,
  output logic                          match
);

  logic [IW-1:0]            pw_idx;
  logic [PW_LEN-1:0][7:0]   entered;
  logic [PW_LEN-1:0][7:0]   pw_rows [NUM_USERS];
  logic [PW_LEN-1:0][7:0]   row;
  logic [PW_LEN-1:0]        mis_vec;
  logic                     is_bs;

  for (genvar u = 0; u < NUM_USERS; u++) begin : g_rows
    assign pw_rows[u] = pw_table[u*PW_LEN*8 +: PW_LEN*8];
  end

  assign row = pw_rows[user_id];

  // Only chars still in the buffer count, so a backspaced typo no longer poisons the result.
  for (genvar g = 0; g < PW_LEN; g++) begin : g_cmp
    assign mis_vec[g] = (g < int'(pw_idx)) && (entered[g] != row[g]);
  end

  assign is_bs = (key_ascii == ASCII_BS);
  assign last  = !is_bs && (int'(pw_idx) == PW_LEN - 1);
  assign match = !(|mis_vec) && (key_ascii == row[pw_idx]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pw_idx  <= '0;
      entered <= '0;
    end else if (clear) begin
      pw_idx <= '0;
    end else if (key_valid) begin
      if (is_bs) begin
        if (pw_idx != '0) pw_idx <= pw_idx - 1'b1;
      end else begin
        entered[pw_idx] <= key_ascii;
        pw_idx          <= pw_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chat_session_ctrl.sv
// rtl/chat_session_ctrl.sv - login/password/send/receive session FSM with lockout and receive tone
module chat_session_ctrl import chat_pkg::*; #(
  parameter int NUM_USERS   = 2,
  parameter int PW_LEN      = 1,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 50_000_000,
  parameter int TONE_CYCLES = 12_500_000,
  localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int FW = $clog2(MAX_FAILS + 1)
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          key_valid,
  input  logic [7:0]                    key_ascii,
  input  logic                          logout,
  input  logic                          rx_valid,
  input  logic [NUM_USERS*PW_LEN*8-1:0] pw_table,
  input  logic                          send_ack,
  output logic [2:0]                    state,
  output logic [UW-1:0]                 user_id,
  output logic                          key_fwd,
  output logic                          lcd_clear,
  output logic                          send_req,
  output logic                          tone_en,
  output logic [FW-1:0]                 fail_cnt
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(TONE_CYCLES + 1);

  logic [2:0]    state_d;
  logic [UW-1:0] user_d;
  logic [FW-1:0] fail_d;
  logic [LW-1:0] lock_cnt, lock_d;
  logic [TW-1:0] tone_cnt, tcnt_d;
  logic          fwd_d, send_d, tone_d, pend_d, rx_pending;
  logic          retry, chk_clear, chk_key, user_key, pw_last, pw_match;

  assign chk_key  = key_valid && !logout && (state == ST_PASSWORD);
  assign user_key = (key_ascii >= ASCII_ONE) && (key_ascii <= 8'(ASCII_ONE + NUM_USERS - 1));

  pw_checker #(
    .NUM_USERS (NUM_USERS),
    .PW_LEN    (PW_LEN)
  ) u_pw_checker (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (chk_clear),
    .key_valid (chk_key),
    .key_ascii (key_ascii),
    .user_id   (user_id),
    .pw_table  (pw_table),
    .last      (pw_last),
    .match     (pw_match)
  );

  always_comb begin
    state_d   = state;
    user_d    = user_id;
    fail_d    = fail_cnt;
    lock_d    = lock_cnt;
    tcnt_d    = tone_cnt;
    fwd_d     = 1'b0;
    send_d    = send_req;
    tone_d    = tone_en;
    pend_d    = rx_pending;
    retry     = 1'b0;
    chk_clear = 1'b0;

    // Lockout is deaf to every input, logout included.
    if (state == ST_LOCKED) begin
      lock_d = lock_cnt + 1'b1;
      if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
        state_d = ST_LOGIN;
        fail_d  = '0;
        user_d  = '0;
        lock_d  = '0;
      end
    end else if (logout) begin
      state_d   = ST_LOGIN;
      send_d    = 1'b0;
      pend_d    = 1'b0;
      tone_d    = 1'b0;
      tcnt_d    = '0;
      chk_clear = 1'b1;
    end else begin
      case (state)
        ST_LOGIN: begin
          if (key_valid && user_key) begin
            user_d    = UW'(key_ascii - ASCII_ONE);
            chk_clear = 1'b1;
            state_d   = ST_PASSWORD;
          end
        end
        ST_PASSWORD: begin
          if (key_valid) begin
            fwd_d = 1'b1;
            if (pw_last) begin
              chk_clear = 1'b1;
              if (pw_match) begin
                fail_d  = '0;
                state_d = ST_SENDING;
              end else if (int'(fail_cnt) + 1 < MAX_FAILS) begin
                fail_d = fail_cnt + 1'b1;
                retry  = 1'b1;
              end else begin
                state_d = ST_LOCKED;
                lock_d  = '0;
              end
            end
          end
        end
        ST_SENDING: begin
          if (rx_valid) begin
            if (!send_req) begin
              state_d = ST_RECEIVING;
              tone_d  = 1'b1;
              tcnt_d  = '0;
            end else begin
              pend_d = 1'b1;
            end
          end else if (key_valid) begin
            if (key_ascii == ASCII_CR) begin
              if (!send_req) send_d = 1'b1;
            end else begin
              fwd_d = 1'b1;
            end
          end
          // A message that arrived mid-send is shown as soon as the handshake completes.
          if (send_req && send_ack) begin
            send_d = 1'b0;
            if (pend_d) begin
              pend_d  = 1'b0;
              state_d = ST_RECEIVING;
              tone_d  = 1'b1;
              tcnt_d  = '0;
            end
          end
        end
        ST_RECEIVING: begin
          if (rx_valid) begin
            tone_d = 1'b1;
            tcnt_d = '0;
          end else if (key_valid) begin
            state_d = ST_SENDING;
            tone_d  = 1'b0;
            tcnt_d  = '0;
          end else if (tone_en) begin
            if (tone_cnt == TW'(TONE_CYCLES - 1)) begin
              tone_d = 1'b0;
              tcnt_d = '0;
            end else begin
              tcnt_d = tone_cnt + 1'b1;
            end
          end
        end
        default: state_d = ST_LOGIN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_LOGIN;
      user_id    <= '0;
      key_fwd    <= 1'b0;
      lcd_clear  <= 1'b0;
      send_req   <= 1'b0;
      tone_en    <= 1'b0;
      fail_cnt   <= '0;
      rx_pending <= 1'b0;
      lock_cnt   <= '0;
      tone_cnt   <= '0;
    end else begin
      state      <= state_d;
      user_id    <= user_d;
      key_fwd    <= fwd_d;
      lcd_clear  <= (state_d != state) || retry;
      send_req   <= send_d;
      tone_en    <= tone_d;
      fail_cnt   <= fail_d;
      rx_pending <= pend_d;
      lock_cnt   <= lock_d;
      tone_cnt   <= tcnt_d;
    end
  end

endmodule
